// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg : shared widths and return-stack operation decode for the 9-bit CPU
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

   localparam int AW_PC    = 10;
   localparam int RS_DEPTH = 8;

   // Encoding mirrors {jump2sub, retFsub} so decode is a plain cast
   typedef enum logic [1:0] {
      RS_NOP     = 2'b00,
      RS_POP     = 2'b01,
      RS_PUSH    = 2'b10,
      RS_REPLACE = 2'b11
   } rs_op_e;

   function automatic rs_op_e rs_decode(input logic jump2sub, input logic retFsub);
      return rs_op_e'({jump2sub, retFsub});
   endfunction

endpackage

`default_nettype wire

// File: rtl/return_stack.sv
// ---------------------------------------------------------------------------
// return_stack : circular return-address stack beside the program counter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module return_stack
   import cpu_pkg::*;
#(
   parameter int DEPTH = RS_DEPTH,
   parameter int AW    = AW_PC
) (
   input  logic                       clk,
   input  logic                       start,
   input  logic                       jump2sub,
   input  logic                       retFsub,
   input  logic [AW-1:0]              npc,
   output logic [AW-1:0]              rl,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int              CW     = $clog2(DEPTH+1);
   localparam int              SPW    = $clog2(DEPTH);
   localparam logic [CW-1:0]   C_FULL = CW'(DEPTH);

   logic [AW-1:0]  mem_q [DEPTH];
   logic [SPW-1:0] sp_q, sp_d;
   logic [CW-1:0]  count_q, count_d;
   logic           ovf_q, ovf_d;
   logic           unf_q, unf_d;
   logic           wr_en;
   logic [SPW-1:0] wr_addr;
   rs_op_e         op;

   assign op = rs_decode(jump2sub, retFsub);

   always_comb begin
      sp_d    = sp_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      wr_en   = 1'b0;
      wr_addr = sp_q;
      case (op)
         RS_PUSH: begin
            sp_d    = sp_q + 1'b1;
            wr_en   = 1'b1;
            wr_addr = sp_q + 1'b1;
            // When full the pointer wraps onto the oldest entry
            if (count_q == C_FULL) ovf_d = 1'b1;
            else                   count_d = count_q + 1'b1;
         end
         RS_POP: begin
            if (count_q != '0) begin
               sp_d    = sp_q - 1'b1;
               count_d = count_q - 1'b1;
            end else begin
               unf_d = 1'b1;
            end
         end
         RS_REPLACE: begin
            wr_en = 1'b1;
            if (count_q == '0) begin
               sp_d    = sp_q + 1'b1;
               wr_addr = sp_q + 1'b1;
               count_d = count_q + 1'b1;
               unf_d   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (start) begin
         sp_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         sp_q    <= sp_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Storage is deliberately left unreset
   always_ff @(posedge clk) begin
      if (wr_en && !start) mem_q[wr_addr] <= npc;
   end

   assign rl        = (count_q != '0) ? mem_q[sp_q] : '0;
   assign count     = count_q;
   assign empty     = (count_q == '0);
   assign full      = (count_q == C_FULL);
   assign overflow  = ovf_q;
   assign underflow = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_return_stack.sv
// ---------------------------------------------------------------------------
// tb_return_stack : scoreboard bench for return_stack against a queue model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_return_stack;

   localparam int DEPTH = 8;
   localparam int AW    = 10;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          start = 1'b1;
   logic          jump2sub = 1'b0;
   logic          retFsub = 1'b0;
   logic [AW-1:0] npc = '0;
   logic [AW-1:0] rl;
   logic [CW-1:0] count;
   logic          empty, full, overflow, underflow;

   return_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk       (clk),
      .start     (start),
      .jump2sub  (jump2sub),
      .retFsub   (retFsub),
      .npc       (npc),
      .rl        (rl),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .overflow  (overflow),
      .underflow (underflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] rl;
      logic [CW-1:0] count;
      logic          empty;
      logic          full;
      logic          ovf;
      logic          unf;
   } exp_t;

   exp_t          sb[$];
   logic [AW-1:0] m_stk[$];
   logic          m_ovf = 1'b0;
   logic          m_unf = 1'b0;
   int            n_cmp = 0;
   int            n_err = 0;

   // Reference model: a bounded list of return addresses, newest at the back
   task automatic model_apply(input logic s, input logic j, input logic r, input logic [AW-1:0] a);
      exp_t e;
      if (s) begin
         m_stk.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else if (j && !r) begin
         if (m_stk.size() == DEPTH) begin
            void'(m_stk.pop_front());
            m_ovf = 1'b1;
         end
         m_stk.push_back(a);
      end else if (r && !j) begin
         if (m_stk.size() > 0) void'(m_stk.pop_back());
         else                  m_unf = 1'b1;
      end else if (r && j) begin
         if (m_stk.size() > 0) m_stk[m_stk.size()-1] = a;
         else begin
            m_stk.push_back(a);
            m_unf = 1'b1;
         end
      end
      e.rl    = (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : '0;
      e.count = CW'(m_stk.size());
      e.empty = (m_stk.size() == 0);
      e.full  = (m_stk.size() == DEPTH);
      e.ovf   = m_ovf;
      e.unf   = m_unf;
      sb.push_back(e);
   endtask

   task automatic step(input logic s, input logic j, input logic r, input logic [AW-1:0] a);
      @(negedge clk);
      start    = s;
      jump2sub = j;
      retFsub  = r;
      npc      = a;
      model_apply(s, j, r, a);
   endtask

   // Monitor: the DUT presents a new state after every edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (rl !== e.rl || count !== e.count || empty !== e.empty || full !== e.full ||
                overflow !== e.ovf || underflow !== e.unf) begin
               n_err++;
               $display("FAIL state @%0t: got rl=%h cnt=%0d e=%b f=%b ov=%b un=%b, want rl=%h cnt=%0d e=%b f=%b ov=%b un=%b",
                        $time, rl, count, empty, full, overflow, underflow,
                        e.rl, e.count, e.empty, e.full, e.ovf, e.unf);
            end
         end
      end
   end

   initial begin
      step(1, 0, 0, '0);
      step(1, 1, 0, 10'h3FF);
      // single push then pop
      step(0, 1, 0, 10'h105);
      step(0, 0, 1, '0);
      // nested calls
      step(0, 1, 0, 10'h010);
      step(0, 1, 0, 10'h020);
      step(0, 1, 0, 10'h030);
      for (int i = 0; i < 3; i++) step(0, 0, 1, '0);
      // nine pushes wrap, eight pops drain
      for (int i = 1; i <= 9; i++) step(0, 1, 0, AW'(i));
      for (int i = 0; i < 8; i++) step(0, 0, 1, '0);
      // pop on empty then push
      step(1, 0, 0, '0);
      step(0, 0, 1, '0);
      step(0, 1, 0, 10'h0AA);
      // replace top
      step(1, 0, 0, '0);
      step(0, 1, 0, 10'h033);
      step(0, 1, 0, 10'h040);
      step(0, 1, 1, 10'h077);
      step(0, 0, 1, '0);
      // replace on empty acts as push with underflow
      step(0, 0, 1, '0);
      step(0, 1, 1, 10'h155);
      // reset during a push sequence
      step(0, 1, 0, 10'h001);
      step(0, 1, 0, 10'h002);
      step(0, 1, 0, 10'h003);
      step(1, 1, 0, 10'h004);
      step(0, 0, 0, '0);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom), AW'($urandom));
      end
      step(0, 0, 0, '0);
      @(posedge clk);
      #2;
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
